// File: rtl/side_request_detector_pkg.sv
// Shared types and light codes for the side-road request front-end.
package side_req_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    SERVING = 2'd2,
    CLEAR   = 2'd3
  } state_t;

  localparam logic [2:0] LT_GREEN  = 3'b001;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_RED    = 3'b100;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == LT_GREEN) || (v == LT_YELLOW) || (v == LT_RED);
  endfunction

endpackage

// File: rtl/side_request_detector_sync_debounce.sv
// Synchronizer chain plus level debouncer; rise marks the cycle dout goes high.
module sync_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [3:0]             cnt;
  logic                   synced;
  logic                   differ;
  logic                   flip;

  assign synced = sync_q[SYNC_STAGES-1];
  assign differ = synced != dout;
  // Toggle only after DEB_CYCLES consecutive samples disagree with the current level.
  assign flip   = differ && (cnt == 4'(DEB_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      cnt    <= '0;
      dout   <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      rise   <= flip && !dout;
      if (flip) begin
        dout <= ~dout;
        cnt  <= '0;
      end else if (differ) begin
        cnt <= cnt + 4'd1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/side_request_detector.sv
// Side-road request generator: debounced loop/button requests, served tracking, light fault watch.
//   state   | meaning
//   IDLE    | no request latched, sensor low
//   ARMED   | request latched, waiting for side green
//   SERVING | side green, sensor follows vehicle presence
//   CLEAR   | side back to red, sensor held low for HOLD_MIN cycles
module side_request_detector
  import side_req_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_MIN    = 3,
  parameter int WAIT_W      = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              loop_raw,
  input  logic              ped_btn_raw,
  input  logic [2:0]        M,
  input  logic [2:0]        S,
  output logic              sensor,
  output logic              req_pending,
  output logic              served,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic              fault
);

  state_t     state, state_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic       loop_deb, loop_rise;
  logic       ped_deb, ped_rise;
  logic       ped_req;
  logic       light_bad, fault_nxt;
  logic       enter_serving;
  logic       sensor_nxt;
  logic       unused;

  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_loop (
    .clock (clock),
    .reset (reset),
    .din   (loop_raw),
    .dout  (loop_deb),
    .rise  (loop_rise)
  );

  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_ped (
    .clock (clock),
    .reset (reset),
    .din   (ped_btn_raw),
    .dout  (ped_deb),
    .rise  (ped_rise)
  );

  assign unused = &{1'b0, loop_rise, ped_deb};

  assign light_bad = !is_onehot3(M) || !is_onehot3(S) || ((M != LT_RED) && (S != LT_RED));
  assign fault_nxt = fault || light_bad;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE:    if (ped_req || loop_deb) state_nxt = ARMED;
      ARMED:   if (S == LT_GREEN) state_nxt = SERVING;
      SERVING: if (S == LT_RED) begin
                 state_nxt = CLEAR;
                 hold_nxt  = 4'(HOLD_MIN - 1);
               end
      CLEAR:   if (hold_cnt == 4'd0) state_nxt = IDLE;
               else hold_nxt = hold_cnt - 4'd1;
      default: state_nxt = IDLE;
    endcase
    // A detected fault freezes the FSM on the very cycle it is seen.
    if (fault_nxt) begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
    end
  end

  assign enter_serving = (state_nxt == SERVING) && (state != SERVING);

  always_comb begin
    sensor_nxt = 1'b0;
    if (!fault_nxt) begin
      case (state_nxt)
        ARMED:   sensor_nxt = 1'b1;
        SERVING: sensor_nxt = loop_deb;
        default: sensor_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      ped_req     <= 1'b0;
      fault       <= 1'b0;
      sensor      <= 1'b0;
      req_pending <= 1'b0;
      served      <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      fault       <= fault_nxt;
      sensor      <= sensor_nxt;
      req_pending <= !fault_nxt && (state_nxt == ARMED);
      served      <= enter_serving;
      // A press during side green belongs to the crossing already under way.
      if (enter_serving) ped_req <= 1'b0;
      else if (ped_rise && (S != LT_GREEN)) ped_req <= 1'b1;
      if (!fault_nxt) begin
        if (state_nxt == IDLE) wait_cnt <= '0;
        else if ((state == ARMED) && (wait_cnt != '1)) wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_side_request_detector.sv
// Scoreboard bench: driver runs a behavioural model per cycle, monitor compares after each edge.
module tb_side_request_detector;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 3;
  localparam int WW   = 8;
  localparam logic [2:0] G = 3'b001, Y = 3'b010, R = 3'b100;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          loop_raw = 1'b0;
  logic          ped_btn_raw = 1'b0;
  logic [2:0]    M = G;
  logic [2:0]    S = R;
  logic          sensor, req_pending, served, fault;
  logic [WW-1:0] wait_cnt;

  side_request_detector #(
    .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .HOLD_MIN(HOLD), .WAIT_W(WW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .loop_raw    (loop_raw),
    .ped_btn_raw (ped_btn_raw),
    .M           (M),
    .S           (S),
    .sensor      (sensor),
    .req_pending (req_pending),
    .served      (served),
    .wait_cnt    (wait_cnt),
    .fault       (fault)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          sensor;
    logic          req_pending;
    logic          served;
    logic [WW-1:0] wait_cnt;
    logic          fault;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model: 0 idle, 1 armed, 2 serving, 3 clear
  int   m_st, m_clr, m_wait;
  int   m_run[2];
  bit   m_deb[2], m_rise[2];
  bit   m_ped_req, m_flt;
  bit   sq0[$], sq1[$];

  function automatic bit onehot(input logic [2:0] v);
    return $countones(v) == 1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_clr = 0; m_wait = 0; m_ped_req = 0; m_flt = 0;
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_deb[k] = 0; m_rise[k] = 0;
    end
    sq0.delete(); sq1.delete();
    for (int k = 0; k < SYNC; k++) begin
      sq0.push_back(1'b0); sq1.push_back(1'b0);
    end
  endtask

  // Synced sample = raw from SYNC edges ago; level flips after DEB disagreeing samples in a row.
  task automatic deb_step(input int k, input bit raw);
    bit o;
    if (k == 0) begin sq0.push_front(raw); o = sq0.pop_back(); end
    else begin sq1.push_front(raw); o = sq1.pop_back(); end
    m_rise[k] = 0;
    if (o != m_deb[k]) begin
      m_run[k]++;
      if (m_run[k] == DEB) begin
        m_deb[k] = !m_deb[k];
        m_rise[k] = m_deb[k];
        m_run[k] = 0;
      end
    end else begin
      m_run[k] = 0;
    end
  endtask

  task automatic model_step(input bit lp, input bit bt, input logic [2:0] mm, input logic [2:0] ss,
                            output obs_t o);
    bit bad, fn, enter;
    int ns;
    bad = !onehot(mm) || !onehot(ss) || (mm != R && ss != R);
    fn  = m_flt || bad;
    ns  = m_st;
    if (!fn) begin
      if (m_st == 0 && (m_ped_req || m_deb[0])) ns = 1;
      else if (m_st == 1 && ss == G) ns = 2;
      else if (m_st == 2 && ss == R) ns = 3;
      else if (m_st == 3 && m_clr == HOLD) ns = 0;
    end
    enter = (ns == 2) && (m_st != 2);
    if (!fn) begin
      if (ns == 0) m_wait = 0;
      else if (m_st == 1 && m_wait < (2 ** WW) - 1) m_wait++;
    end
    o.sensor      = !fn && (ns == 1 || (ns == 2 && m_deb[0]));
    o.req_pending = !fn && (ns == 1);
    o.served      = enter;
    o.wait_cnt    = WW'(m_wait);
    o.fault       = fn;
    if (enter) m_ped_req = 0;
    else if (m_rise[1] && ss != G) m_ped_req = 1;
    if (ns == 3) m_clr = (m_st == 3) ? m_clr + 1 : 1;
    m_st  = ns;
    m_flt = fn;
    deb_step(0, lp);
    deb_step(1, bt);
  endtask

  task automatic step(input bit rst, input bit lp, input bit bt, input logic [2:0] mm, input logic [2:0] ss);
    obs_t o;
    @(negedge clock);
    reset = rst; loop_raw = lp; ped_btn_raw = bt; M = mm; S = ss;
    if (rst) begin
      model_reset();
      o = '0;
    end else begin
      model_step(lp, bt, mm, ss, o);
    end
    exp_q.push_back(o);
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = '{sensor, req_pending, served, wait_cnt, fault};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs at %0t: got sensor=%b req_pending=%b served=%b wait_cnt=%0d fault=%b expected sensor=%b req_pending=%b served=%b wait_cnt=%0d fault=%b",
                   $time, a.sensor, a.req_pending, a.served, a.wait_cnt, a.fault,
                   e.sensor, e.req_pending, e.served, e.wait_cnt, e.fault);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [2:0] seq_m[6];
    logic [2:0] seq_s[6];
    bit lp, bt;
    int bounce, dwell;
    seq_m = '{G, Y, R, R, R, R};
    seq_s = '{R, R, R, G, Y, R};
    model_reset();

    // Reset with the loop already occupied, then release
    repeat (3) step(1, 1, 0, G, R);
    check("reset_sensor", int'(sensor), 0);
    repeat (12) step(0, 1, 0, G, R);

    // Long wait in ARMED saturates the counter, then serve it
    repeat (300) step(0, 1, 0, G, R);
    check("wait_saturated", int'(wait_cnt), 255);
    repeat (2) step(0, 1, 0, Y, R);
    repeat (2) step(0, 1, 0, R, R);
    repeat (4) step(0, 1, 0, R, G);

    // Vehicles leave during green, then side returns to red
    repeat (10) step(0, 0, 0, R, G);
    repeat (2) step(0, 0, 0, R, Y);
    repeat (6) step(0, 0, 0, R, R);
    repeat (5) step(0, 0, 0, G, R);

    // Bouncing button then held
    step(0, 0, 1, G, R); step(0, 0, 0, G, R); step(0, 0, 1, G, R); step(0, 0, 0, G, R);
    repeat (10) step(0, 0, 1, G, R);
    repeat (10) step(0, 0, 0, G, R);
    repeat (2) step(0, 0, 0, Y, R);
    repeat (2) step(0, 0, 0, R, R);
    repeat (3) step(0, 0, 0, R, G);

    // Press during side green is dropped
    repeat (8) step(0, 0, 1, R, G);
    repeat (6) step(0, 0, 0, R, G);
    repeat (2) step(0, 0, 0, R, Y);
    repeat (10) step(0, 0, 0, R, R);
    repeat (5) step(0, 0, 0, G, R);

    // Press during side yellow is kept and re-arms after CLEAR
    repeat (10) step(0, 1, 0, G, R);
    repeat (2) step(0, 1, 0, Y, R);
    repeat (2) step(0, 1, 0, R, R);
    repeat (8) step(0, 0, 0, R, G);
    repeat (8) step(0, 0, 1, R, Y);
    repeat (2) step(0, 0, 0, R, Y);
    repeat (10) step(0, 0, 0, R, R);
    repeat (5) step(0, 0, 0, G, R);

    // Randomized traffic with a legal light sequence
    lp = 0; bt = 0; bounce = 0;
    for (int k = 0; k < 90; k++) begin
      dwell = $urandom_range(1, 25);
      for (int j = 0; j < dwell; j++) begin
        if ($urandom_range(0, 15) == 0) lp = !lp;
        if (bounce > 0) begin
          bt = 1'($urandom_range(0, 1));
          bounce--;
        end else if ($urandom_range(0, 20) == 0) begin
          bt = !bt;
          bounce = $urandom_range(0, 4);
        end
        step(0, lp, bt, seq_m[k % 6], seq_s[k % 6]);
      end
    end

    // Illegal lights latch a sticky fault
    repeat (2) step(1, 0, 0, G, R);
    repeat (12) step(0, 1, 0, G, R);
    step(0, 1, 0, G, G);
    repeat (10) step(0, 1, 0, G, R);
    check("fault_sticky", int'(fault), 1);
    check("fault_sensor", int'(sensor), 0);
    step(0, 1, 0, 3'b011, R);
    repeat (3) step(0, 1, 0, R, R);

    // Async reset mid-ARMED clears outputs before the next edge
    repeat (2) step(1, 1, 0, G, R);
    repeat (14) step(0, 1, 0, G, R);
    check("armed_before_reset", int'(req_pending), 1);
    step(1, 1, 0, G, R);
    #1;
    check("async_reset", int'({sensor, req_pending, served, wait_cnt, fault}), 0);
    repeat (2) step(1, 1, 0, G, R);
    repeat (10) step(0, 1, 0, G, R);

    repeat (3) @(posedge clock);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
